// File: rtl/id_stage_pipe.sv
// Registered RV32 decode stage: combinational decode of the fetched word, load-use interlock,
// and a valid/ready output register that decouples fetch from execute.
module id_stage_pipe #(
    parameter int unsigned XLEN      = 32,
    parameter bit          M_EXT     = 1'b1,
    parameter bit          HAZARD_EN = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [XLEN-1:0]  in_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_pc,
    output logic [4:0]       out_rs1_addr,
    output logic [4:0]       out_rs2_addr,
    output logic [4:0]       out_rd_addr,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_rmem,
    output logic             out_wmem,
    output logic             out_wen,
    output logic             out_jmp,
    output logic             out_jcc,
    output logic             out_lui,
    output logic             out_jal,
    output logic             out_jalr,
    output logic             out_inst_R,
    output logic             out_mem_sign,
    output logic             out_sign,
    output logic             out_sub,
    output logic [3:0]       out_alu_ctrl,
    output logic [1:0]       out_mem_type,
    output logic             out_muldiv,
    output logic [2:0]       out_muldiv_op,
    output logic             out_illegal,
    output logic [CNT_W-1:0] bubble_cnt
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            rmem, wmem, wen, jmp, jcc, lui, jal, jalr;
        logic            inst_r, mem_sign, sign, sub;
        logic [3:0]      alu_ctrl;
        logic [1:0]      mem_type;
        logic            muldiv;
        logic [2:0]      muldiv_op;
        logic            illegal;
    } bundle_t;

    bundle_t          r_b;
    bundle_t          w_b;
    logic             r_valid;
    logic [CNT_W-1:0] r_bubble_cnt;

    logic [6:0]  w_opc;
    logic [2:0]  w_f3;
    logic [6:0]  w_f7;
    logic        w_lui, w_auipc, w_jal, w_jalr, w_br, w_load, w_store, w_opimm, w_op;
    logic        w_misc, w_sys, w_known, w_mul, w_illegal;
    logic        w_uses_rs1, w_uses_rs2, w_hazard, w_accept;
    logic [31:0] w_imm32;

    assign w_opc   = in_inst[6:0];
    assign w_f3    = in_inst[14:12];
    assign w_f7    = in_inst[31:25];
    assign w_lui   = (w_opc == 7'b0110111);
    assign w_auipc = (w_opc == 7'b0010111);
    assign w_jal   = (w_opc == 7'b1101111);
    assign w_jalr  = (w_opc == 7'b1100111);
    assign w_br    = (w_opc == 7'b1100011);
    assign w_load  = (w_opc == 7'b0000011);
    assign w_store = (w_opc == 7'b0100011);
    assign w_opimm = (w_opc == 7'b0010011);
    assign w_op    = (w_opc == 7'b0110011);
    assign w_misc  = (w_opc == 7'b0001111);
    assign w_sys   = (w_opc == 7'b1110011);

    assign w_known = w_lui | w_auipc | w_jal | w_jalr | w_br | w_load | w_store |
                     w_opimm | w_op | w_misc | w_sys;
    assign w_mul     = w_op & (w_f7 == 7'b0000001);
    assign w_illegal = (in_inst[1:0] != 2'b11) | ~w_known | (w_mul & ~M_EXT);

    always_comb begin
        w_imm32 = 32'd0;
        if (w_opimm | w_load | w_jalr | w_sys) begin
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
        end else if (w_store) begin
            w_imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
        end else if (w_br) begin
            w_imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                       in_inst[11:8], 1'b0};
        end else if (w_lui | w_auipc) begin
            w_imm32 = {in_inst[31:12], 12'd0};
        end else if (w_jal) begin
            w_imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                       in_inst[30:21], 1'b0};
        end
    end

    always_comb begin
        w_b           = '0;
        w_b.pc        = in_pc;
        w_b.rs1       = in_inst[19:15];
        w_b.rs2       = in_inst[24:20];
        w_b.rd        = in_inst[11:7];
        w_b.imm       = XLEN'($signed(w_imm32));
        w_b.illegal   = w_illegal;
        // Side-effecting flags are suppressed on an illegal encoding.
        w_b.rmem      = w_load & ~w_illegal;
        w_b.wmem      = w_store & ~w_illegal;
        w_b.wen       = (w_lui | w_auipc | w_jal | w_jalr | w_load | w_opimm | w_op) &
                        ~w_illegal;
        w_b.jmp       = (w_jal | w_jalr) & ~w_illegal;
        w_b.jcc       = w_br & ~w_illegal;
        w_b.muldiv    = w_mul & ~w_illegal;
        w_b.muldiv_op = (w_mul & ~w_illegal) ? w_f3 : 3'd0;
        w_b.lui       = w_lui;
        w_b.jal       = w_jal;
        w_b.jalr      = w_jalr;
        w_b.inst_r    = w_op;
        w_b.mem_sign  = w_load & ~w_f3[2];
        w_b.sign      = w_br ? ~w_f3[1] : ((w_op | w_opimm) & (w_f3 == 3'b010));
        w_b.sub       = w_op & ~w_mul & in_inst[30] & (w_f3 == 3'b000);
        w_b.mem_type  = (w_load | w_store) ? w_f3[1:0] : 2'd0;
        if (w_op & ~w_mul) begin
            w_b.alu_ctrl = {in_inst[30], w_f3};
        end else if (w_opimm) begin
            w_b.alu_ctrl = {(w_f3 == 3'b101) & in_inst[30], w_f3};
        end
    end

    assign w_uses_rs1 = ~(w_lui | w_auipc | w_jal);
    assign w_uses_rs2 = w_op | w_store | w_br;
    assign w_hazard   = HAZARD_EN & in_valid & r_valid & r_b.rmem & (r_b.rd != 5'd0) &
                        ((w_uses_rs1 & (in_inst[19:15] == r_b.rd)) |
                         (w_uses_rs2 & (in_inst[24:20] == r_b.rd)));
    assign in_ready   = (~r_valid | out_ready) & ~w_hazard & ~flush;
    assign w_accept   = in_valid & in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid      <= 1'b0;
            r_b          <= '0;
            r_bubble_cnt <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_b     <= w_b;
        end else if (r_valid & out_ready) begin
            r_valid <= 1'b0;
            // The load drains while its consumer is held: that empty slot is the bubble.
            if (w_hazard && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + 1'b1;
            end
        end
    end

    assign out_valid     = r_valid;
    assign out_pc        = r_b.pc;
    assign out_rs1_addr  = r_b.rs1;
    assign out_rs2_addr  = r_b.rs2;
    assign out_rd_addr   = r_b.rd;
    assign out_imm       = r_b.imm;
    assign out_rmem      = r_b.rmem;
    assign out_wmem      = r_b.wmem;
    assign out_wen       = r_b.wen;
    assign out_jmp       = r_b.jmp;
    assign out_jcc       = r_b.jcc;
    assign out_lui       = r_b.lui;
    assign out_jal       = r_b.jal;
    assign out_jalr      = r_b.jalr;
    assign out_inst_R    = r_b.inst_r;
    assign out_mem_sign  = r_b.mem_sign;
    assign out_sign      = r_b.sign;
    assign out_sub       = r_b.sub;
    assign out_alu_ctrl  = r_b.alu_ctrl;
    assign out_mem_type  = r_b.mem_type;
    assign out_muldiv    = r_b.muldiv;
    assign out_muldiv_op = r_b.muldiv_op;
    assign out_illegal   = r_b.illegal;
    assign bubble_cnt    = r_bubble_cnt;

endmodule
